// File: rtl/overlap_framing.sv
// Overlapping framer: stores the input stream once in a circular buffer and
// replays FRAME_LEN-sample windows every HOP_LEN samples on a valid/ready port.
module overlap_framing #(
  parameter int I_BW      = 9,
  parameter int O_BW      = 16,
  parameter int FRAME_LEN = 256,
  parameter int HOP_LEN   = 128,
  parameter int BUF_DEPTH = 384
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [I_BW-1:0]   data_i,
  input  logic              valid_i,
  output logic [O_BW-1:0]   data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              overflow_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(FRAME_LEN);

  localparam logic [AW:0]   DEPTH_A  = (AW + 1)'(BUF_DEPTH);
  localparam logic [AW:0]   HOP_A    = (AW + 1)'(HOP_LEN);
  localparam logic [AW-1:0] PTR_LAST = AW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] FRAME_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] HOP_C    = CW'(HOP_LEN);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_UNLOAD = 1'b1;

  // Modular add for buffer addresses; off never exceeds BUF_DEPTH, so one subtract suffices.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input logic [AW:0] off);
    logic [AW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= DEPTH_A) begin
      wrap_add = AW'(sum - DEPTH_A);
    end else begin
      wrap_add = sum[AW-1:0];
    end
  endfunction

  function automatic logic [O_BW-1:0] sext(input logic [I_BW-1:0] s);
    sext = O_BW'($signed(s));
  endfunction

  logic [I_BW-1:0] mem_q [BUF_DEPTH];

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   fs_ptr_q, fs_ptr_d;
  logic [CW-1:0]   avail_q, avail_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [O_BW-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            ovf_q, ovf_d;

  logic            wr_acc_s;
  logic            hs_s;
  logic            done_s;
  logic [IW-1:0]   idx_next_s;
  logic [IW-1:0]   rd_idx_s;
  logic [AW-1:0]   rd_addr_s;

  // Handshake, write-accept and read-address decode
  always_comb begin
    wr_acc_s   = valid_i && (avail_q < DEPTH_C);
    hs_s       = valid_q && ready_i;
    done_s     = (state_q == ST_UNLOAD) && hs_s && (idx_q == IDX_LAST);
    idx_next_s = idx_q + IW'(1);
    if (state_q == ST_UNLOAD) begin
      rd_idx_s = idx_next_s;
    end else begin
      rd_idx_s = {IW{1'b0}};
    end
    rd_addr_s  = wrap_add(fs_ptr_q, (AW + 1)'(rd_idx_s));
  end

  // Next-state logic for pointers, occupancy, FSM and output register
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fs_ptr_d = fs_ptr_q;
    avail_d  = avail_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    ovf_d    = ovf_q;

    if (wr_acc_s) begin
      if (wr_ptr_q == PTR_LAST) begin
        wr_ptr_d = {AW{1'b0}};
      end else begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (valid_i && !wr_acc_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    // Frame completion releases HOP_LEN slots on the same edge a write may claim one.
    if (done_s) begin
      avail_d = avail_q - HOP_C + {{(CW-1){1'b0}}, wr_acc_s};
    end else begin
      avail_d = avail_q + {{(CW-1){1'b0}}, wr_acc_s};
    end

    case (state_q)
      ST_LOAD: begin
        if (avail_q >= FRAME_C) begin
          state_d = ST_UNLOAD;
          idx_d   = {IW{1'b0}};
          data_d  = sext(mem_q[rd_addr_s]);
          valid_d = 1'b1;
          last_d  = 1'b0;
        end else begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_UNLOAD: begin
        if (hs_s) begin
          if (idx_q == IDX_LAST) begin
            fs_ptr_d = wrap_add(fs_ptr_q, HOP_A);
            valid_d  = 1'b0;
            last_d   = 1'b0;
            state_d  = ST_LOAD;
          end else begin
            idx_d  = idx_next_s;
            data_d = sext(mem_q[rd_addr_s]);
            last_d = (idx_next_s == IDX_LAST);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Sample storage; unread slots are never observed because avail gates every read
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Control and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= {AW{1'b0}};
      fs_ptr_q <= {AW{1'b0}};
      avail_q  <= {CW{1'b0}};
      idx_q    <= {IW{1'b0}};
      data_q   <= {O_BW{1'b0}};
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fs_ptr_q <= fs_ptr_d;
      avail_q  <= avail_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign overflow_o = ovf_q;

endmodule
